// File: rtl/mpmc11_pkg.sv
// Shared mpmc11 definitions: channel state encoding and memory-interface
// command codes, used by the burst sequencer and the address generator.
package mpmc11_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PRESET1,
        PRESET2,
        READ_DATA0,
        READ_DATA1,
        READ_DATA2,
        WRITE_DATA0,
        WRITE_DATA1,
        WAIT_NACK
    } mpmc11_state_t;

    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b000;

    function automatic logic is_read_state(input mpmc11_state_t s);
        return (s == READ_DATA0) || (s == READ_DATA1) || (s == READ_DATA2);
    endfunction

endpackage

// File: rtl/mpmc11_burst_ctrl.sv
// Per-channel burst sequencer: accepts one read burst or single-beat write,
// issues memory commands and counts returned read beats for completion.
module mpmc11_burst_ctrl
    import mpmc11_pkg::*;
#(
    parameter int unsigned WID    = 256,
    parameter logic [2:0]  CMD_RD = mpmc11_pkg::CMD_RD,
    parameter logic [2:0]  CMD_WR = mpmc11_pkg::CMD_WR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          calib_done,
    input  logic          req,
    input  logic          req_we,
    input  logic [31:0]   req_adr,
    input  logic [5:0]    req_len,
    input  logic          mem_rdy,
    input  logic          wdf_rdy,
    input  logic          rd_data_valid,
    output mpmc11_state_t state,
    output logic [5:0]    burst_len,
    output logic [5:0]    burst_cnt,
    output logic [31:0]   addr_base,
    output logic          cmd_en,
    output logic [2:0]    cmd,
    output logic          wdf_wren,
    output logic          wdf_end,
    output logic          rd_beat,
    output logic          done
);

    if (WID == 0 || (WID % 8) != 0) begin : g_bad_wid
        $error("mpmc11_burst_ctrl: WID must be a non-zero multiple of 8");
    end

    mpmc11_state_t state_q, state_d;
    logic [5:0]    burst_len_q, burst_len_d;
    logic [5:0]    burst_cnt_q, burst_cnt_d;
    logic [31:0]   addr_base_q, addr_base_d;
    logic          we_q, we_d;
    logic [6:0]    beat_cnt_q, beat_cnt_d;
    logic          rd_beat_q, rd_beat_d;
    logic          done_q, done_d;
    logic          beat_inc;
    logic [6:0]    beat_sum;

    // Command strobes depend on state only so reset removes them at once.
    always_comb begin
        cmd_en   = 1'b0;
        cmd      = CMD_WR;
        wdf_wren = 1'b0;
        unique case (state_q)
            READ_DATA0, READ_DATA2: begin
                cmd_en = 1'b1;
                cmd    = CMD_RD;
            end
            WRITE_DATA0: wdf_wren = 1'b1;
            WRITE_DATA1: cmd_en   = 1'b1;
            default: ;
        endcase
    end

    assign wdf_end = wdf_wren;

    always_comb begin
        beat_inc    = rd_data_valid && is_read_state(state_q);
        // 7-bit sum so a 64-beat burst reaches 64 instead of wrapping to 0.
        beat_sum    = beat_cnt_q + {6'd0, beat_inc};
        state_d     = state_q;
        burst_len_d = burst_len_q;
        burst_cnt_d = burst_cnt_q;
        addr_base_d = addr_base_q;
        we_d        = we_q;
        beat_cnt_d  = beat_sum;
        rd_beat_d   = beat_inc;
        done_d      = done_q;
        unique case (state_q)
            IDLE: begin
                if (calib_done && req) begin
                    addr_base_d = req_adr;
                    we_d        = req_we;
                    burst_len_d = req_we ? 6'd0 : req_len;
                    burst_cnt_d = '0;
                    beat_cnt_d  = '0;
                    state_d     = PRESET1;
                end
            end
            PRESET1: state_d = PRESET2;
            PRESET2: state_d = we_q ? WRITE_DATA0 : READ_DATA0;
            READ_DATA0: begin
                if (mem_rdy) begin
                    if (burst_len_q == 6'd0) begin
                        state_d = READ_DATA1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 6'd1;
                        state_d     = READ_DATA2;
                    end
                end
            end
            READ_DATA2: begin
                if (mem_rdy) begin
                    if (burst_cnt_q == burst_len_q) begin
                        state_d = READ_DATA1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 6'd1;
                    end
                end
            end
            READ_DATA1: begin
                if (beat_sum == ({1'b0, burst_len_q} + 7'd1)) begin
                    state_d = WAIT_NACK;
                    done_d  = 1'b1;
                end
            end
            WRITE_DATA0: if (wdf_rdy) state_d = WRITE_DATA1;
            WRITE_DATA1: begin
                if (mem_rdy) begin
                    state_d = WAIT_NACK;
                    done_d  = 1'b1;
                end
            end
            WAIT_NACK: begin
                if (!req) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            burst_len_q <= '0;
            burst_cnt_q <= '0;
            addr_base_q <= '0;
            we_q        <= 1'b0;
            beat_cnt_q  <= '0;
            rd_beat_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_len_q <= burst_len_d;
            burst_cnt_q <= burst_cnt_d;
            addr_base_q <= addr_base_d;
            we_q        <= we_d;
            beat_cnt_q  <= beat_cnt_d;
            rd_beat_q   <= rd_beat_d;
            done_q      <= done_d;
        end
    end

    assign state     = state_q;
    assign burst_len = burst_len_q;
    assign burst_cnt = burst_cnt_q;
    assign addr_base = addr_base_q;
    assign rd_beat   = rd_beat_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mpmc11_burst_ctrl.sv
// Directed bench for mpmc11_burst_ctrl: vector table for the basic read
// handshake plus hand-written multi-cycle read, write and reset sequences.
module tb_mpmc11_burst_ctrl;
    import mpmc11_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          calib_done, req, req_we, mem_rdy, wdf_rdy, rd_data_valid;
    logic [31:0]   req_adr;
    logic [5:0]    req_len;
    mpmc11_state_t state;
    logic [5:0]    burst_len, burst_cnt;
    logic [31:0]   addr_base;
    logic          cmd_en, wdf_wren, wdf_end, rd_beat, done;
    logic [2:0]    cmd;

    int n_cmp = 0;
    int n_bad = 0;
    int cmd_count = 0;
    int wren_count = 0;
    int base;

    mpmc11_burst_ctrl #(.WID(256)) dut (
        .clk(clk), .rst(rst), .calib_done(calib_done), .req(req),
        .req_we(req_we), .req_adr(req_adr), .req_len(req_len),
        .mem_rdy(mem_rdy), .wdf_rdy(wdf_rdy), .rd_data_valid(rd_data_valid),
        .state(state), .burst_len(burst_len), .burst_cnt(burst_cnt),
        .addr_base(addr_base), .cmd_en(cmd_en), .cmd(cmd),
        .wdf_wren(wdf_wren), .wdf_end(wdf_end), .rd_beat(rd_beat), .done(done)
    );

    always #5 clk = ~clk;

    // Handshakes accepted at each edge, seen from the bench side.
    always @(posedge clk) begin
        if (rst && cmd_en && mem_rdy) cmd_count++;
        if (rst && wdf_wren && wdf_rdy) wren_count++;
    end

    typedef struct {
        logic          calib, rq, mr, rdv;
        mpmc11_state_t st;
        logic [5:0]    bcnt;
        logic          cen;
        logic [2:0]    cmdv;
        logic          wren, rbeat, dn;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic we, input logic [31:0] adr, input logic [5:0] len);
        calib_done = 1'b1; req = 1'b1; req_we = we; req_adr = adr; req_len = len;
        mem_rdy = 1'b0; wdf_rdy = 1'b0; rd_data_valid = 1'b0;
        cyc; cyc; cyc;
    endtask

    task automatic step(input logic mr, input logic rdv, input mpmc11_state_t st,
                        input logic [5:0] bc, input string tag);
        mem_rdy = mr; rd_data_valid = rdv;
        cyc;
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " burst_cnt"}, 32'(burst_cnt), 32'(bc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        calib_done = 1'b0; req = 1'b0; req_we = 1'b0; req_adr = '0; req_len = '0;
        mem_rdy = 1'b0; wdf_rdy = 1'b0; rd_data_valid = 1'b0;
        #12;
        check("rst state", 32'(state), 32'(IDLE));
        check("rst burst_len", 32'(burst_len), 32'd0);
        check("rst burst_cnt", 32'(burst_cnt), 32'd0);
        check("rst addr_base", addr_base, 32'd0);
        check("rst cmd_en", 32'(cmd_en), 32'd0);
        check("rst cmd", 32'(cmd), 32'(CMD_WR));
        check("rst wren_end", {30'd0, wdf_wren, wdf_end}, 32'd0);
        check("rst rd_beat_done", {30'd0, rd_beat, done}, 32'd0);
        rst = 1'b1;

        // Single-beat read with a calib_done gate; calib drop mid-burst ignored.
        req_we = 1'b0; req_adr = 32'h1000; req_len = 6'd0;
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, IDLE,       6'd0, 1'b0, CMD_WR, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, IDLE,       6'd0, 1'b0, CMD_WR, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, PRESET1,    6'd0, 1'b0, CMD_WR, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, PRESET2,    6'd0, 1'b0, CMD_WR, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, READ_DATA0, 6'd0, 1'b1, CMD_RD, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, READ_DATA0, 6'd0, 1'b1, CMD_RD, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, READ_DATA1, 6'd0, 1'b0, CMD_WR, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, READ_DATA1, 6'd0, 1'b0, CMD_WR, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b1, WAIT_NACK,  6'd0, 1'b0, CMD_WR, 1'b0, 1'b1, 1'b1});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, WAIT_NACK,  6'd0, 1'b0, CMD_WR, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, IDLE,       6'd0, 1'b0, CMD_WR, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, IDLE,       6'd0, 1'b0, CMD_WR, 1'b0, 1'b0, 1'b0});

        base = cmd_count;
        foreach (vq[i]) begin
            calib_done = vq[i].calib; req = vq[i].rq;
            mem_rdy = vq[i].mr; rd_data_valid = vq[i].rdv;
            cyc;
            check($sformatf("vec%0d state", i), 32'(state), 32'(vq[i].st));
            check($sformatf("vec%0d burst_cnt", i), 32'(burst_cnt), 32'(vq[i].bcnt));
            check($sformatf("vec%0d cmd_en", i), 32'(cmd_en), 32'(vq[i].cen));
            check($sformatf("vec%0d cmd", i), 32'(cmd), 32'(vq[i].cmdv));
            check($sformatf("vec%0d wdf_wren", i), 32'(wdf_wren), 32'(vq[i].wren));
            check($sformatf("vec%0d wdf_end", i), 32'(wdf_end), 32'(vq[i].wren));
            check($sformatf("vec%0d rd_beat", i), 32'(rd_beat), 32'(vq[i].rbeat));
            check($sformatf("vec%0d done", i), 32'(done), 32'(vq[i].dn));
        end
        check("len0 commands", 32'(cmd_count - base), 32'd1);
        check("len0 addr_base", addr_base, 32'h1000);

        // Read of 4 beats with toggling mem_rdy and beats returning during READ_DATA2.
        base = cmd_count;
        start(1'b0, 32'h2000, 6'd3);
        check("len3 start", 32'(state), 32'(READ_DATA0));
        check("len3 burst_len", 32'(burst_len), 32'd3);
        step(1'b1, 1'b0, READ_DATA2, 6'd1, "len3 s1");
        step(1'b0, 1'b1, READ_DATA2, 6'd1, "len3 s2");
        check("len3 rd_beat in RD2", 32'(rd_beat), 32'd1);
        step(1'b1, 1'b0, READ_DATA2, 6'd2, "len3 s3");
        step(1'b1, 1'b1, READ_DATA2, 6'd3, "len3 s4");
        step(1'b0, 1'b0, READ_DATA2, 6'd3, "len3 s5");
        step(1'b1, 1'b0, READ_DATA1, 6'd3, "len3 s6");
        check("len3 commands", 32'(cmd_count - base), 32'd4);
        step(1'b0, 1'b1, READ_DATA1, 6'd3, "len3 beat3");
        req = 1'b0;
        step(1'b0, 1'b0, READ_DATA1, 6'd3, "len3 reqdrop");
        step(1'b0, 1'b1, WAIT_NACK, 6'd3, "len3 beat4");
        check("len3 done", 32'(done), 32'd1);
        step(1'b0, 1'b0, IDLE, 6'd3, "len3 exit");
        check("len3 done clr", 32'(done), 32'd0);

        // Write: wdf_rdy late, mem_rdy stalls in WRITE_DATA1, burst_len forced to 0.
        base = cmd_count;
        wren_count = 0;
        start(1'b1, 32'h3000, 6'd5);
        check("wr state", 32'(state), 32'(WRITE_DATA0));
        check("wr burst_len", 32'(burst_len), 32'd0);
        check("wr wdf_wren", {30'd0, wdf_wren, wdf_end}, 32'd3);
        check("wr cmd_en WD0", 32'(cmd_en), 32'd0);
        mem_rdy = 1'b1;
        cyc; cyc;
        check("wr wait wdf", 32'(state), 32'(WRITE_DATA0));
        wdf_rdy = 1'b1; mem_rdy = 1'b0;
        cyc;
        wdf_rdy = 1'b0;
        check("wr state WD1", 32'(state), 32'(WRITE_DATA1));
        check("wr cmd_en WD1", {28'd0, cmd_en, cmd}, {28'd0, 1'b1, CMD_WR});
        check("wr wren off", 32'(wdf_wren), 32'd0);
        cyc; cyc;
        check("wr mem stall", 32'(state), 32'(WRITE_DATA1));
        mem_rdy = 1'b1;
        cyc;
        mem_rdy = 1'b0;
        check("wr state nack", 32'(state), 32'(WAIT_NACK));
        check("wr done", 32'(done), 32'd1);
        check("wr commands", 32'(cmd_count - base), 32'd1);
        check("wr data beats", 32'(wren_count), 32'd1);
        req = 1'b0;
        cyc;
        check("wr exit", 32'(state), 32'(IDLE));

        // Maximum burst: 64 commands then 64 beats, no early wrap.
        base = cmd_count;
        start(1'b0, 32'h4000, 6'd63);
        mem_rdy = 1'b1;
        for (int i = 0; i < 100 && state != READ_DATA1; i++) cyc;
        mem_rdy = 1'b0;
        check("len63 reached RD1", 32'(state), 32'(READ_DATA1));
        check("len63 commands", 32'(cmd_count - base), 32'd64);
        check("len63 burst_cnt", 32'(burst_cnt), 32'd63);
        check("len63 burst_len", 32'(burst_len), 32'd63);
        rd_data_valid = 1'b1;
        for (int i = 0; i < 63; i++) cyc;
        check("len63 after 63 beats", 32'(state), 32'(READ_DATA1));
        cyc;
        rd_data_valid = 1'b0;
        check("len63 after 64 beats", 32'(state), 32'(WAIT_NACK));
        req = 1'b0;
        cyc;
        check("len63 exit", 32'(state), 32'(IDLE));

        // Asynchronous reset mid-burst, then a fresh 2-beat read.
        start(1'b0, 32'h5000, 6'd5);
        step(1'b1, 1'b0, READ_DATA2, 6'd1, "rstmid s1");
        step(1'b1, 1'b0, READ_DATA2, 6'd2, "rstmid s2");
        rst = 1'b0;
        #1;
        check("rstmid state", 32'(state), 32'(IDLE));
        check("rstmid cmd_en", 32'(cmd_en), 32'd0);
        check("rstmid burst_cnt", 32'(burst_cnt), 32'd0);
        check("rstmid addr_base", addr_base, 32'd0);
        #2;
        rst = 1'b1;
        base = cmd_count;
        start(1'b0, 32'h6000, 6'd1);
        check("post start", 32'(state), 32'(READ_DATA0));
        check("post addr_base", addr_base, 32'h6000);
        step(1'b1, 1'b0, READ_DATA2, 6'd1, "post s1");
        step(1'b1, 1'b0, READ_DATA1, 6'd1, "post s2");
        step(1'b0, 1'b1, READ_DATA1, 6'd1, "post beat1");
        step(1'b0, 1'b1, WAIT_NACK, 6'd1, "post beat2");
        check("post commands", 32'(cmd_count - base), 32'd2);
        req = 1'b0;
        step(1'b0, 1'b0, IDLE, 6'd1, "post exit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mpmc11_burst_ctrl.md
Name: mpmc11_burst_ctrl

Overview:
- Per-channel burst sequencer for the mpmc11 controller.
- Accepts one request at a time: read burst or single-beat write.
- Steps through the shared mpmc11 state encoding and issues memory-interface commands (cmd_en/cmd, write-data strobes).
- Drives state, burst_len, burst_cnt and addr_base directly into the downstream address generator, and counts returned read beats to decide completion.

Parameters:
- WID, 256, memory data width in bits; must match the address generator's WID.
- CMD_RD, 3'b001, command code for read.
- CMD_WR, 3'b000, command code for write.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- calib_done  in  1  memory calibration complete; no request is accepted while low.
- req  in  1  channel request valid; held high until done.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  32  request byte address.
- req_len  in  6  read burst length minus one (0 = one beat); ignored for writes.
- mem_rdy  in  1  memory interface accepts command this cycle.
- wdf_rdy  in  1  write-data FIFO accepts data this cycle.
- rd_data_valid  in  1  one read beat returned this cycle.
- state  out  mpmc11_state_t  current state, to the address generator.
- burst_len  out  6  latched burst length, to the address generator.
- burst_cnt  out  6  commands issued so far in this burst.
- addr_base  out  32  latched req_adr.
- cmd_en  out  1  command valid.
- cmd  out  3  command code.
- wdf_wren  out  1  write-data valid.
- wdf_end  out  1  last write-data beat; always equal to wdf_wren.
- rd_beat  out  1  registered copy of rd_data_valid for downstream capture.
- done  out  1  request complete, held until req drops.

Behaviour:
- Reset (rst low, asynchronous) sets:
  - state=IDLE
  - burst_len=0, burst_cnt=0, addr_base=0
  - cmd_en=0, cmd=CMD_WR
  - wdf_wren=0, wdf_end=0, rd_beat=0, done=0
  - beat counter=0
- All outputs are registered, except that cmd_en, cmd, wdf_wren and wdf_end are decoded combinationally from state only.
- State transitions:
  - IDLE: if calib_done & req, latch req_adr→addr_base, req_we, and burst_len (req_len for reads, 0 for writes); clear burst_cnt and the beat counter; go to PRESET1. Otherwise stay.
  - PRESET1: one settle cycle → PRESET2.
  - PRESET2: the address generator loads the aligned base here. Go to READ_DATA0 if read, else WRITE_DATA0.
  - READ_DATA0: cmd_en=1, cmd=CMD_RD. On mem_rdy: if burst_len==0 go to READ_DATA1; else burst_cnt+1 and go to READ_DATA2. Without mem_rdy, hold.
  - READ_DATA2: cmd_en=1, cmd=CMD_RD. On mem_rdy: if burst_cnt==burst_len go to READ_DATA1; else burst_cnt+1.
  - READ_DATA1: cmd_en=0. Wait until the beat counter reaches burst_len+1, then go to WAIT_NACK.
  - WRITE_DATA0: wdf_wren=wdf_end=1. On wdf_rdy → WRITE_DATA1.
  - WRITE_DATA1: cmd_en=1, cmd=CMD_WR. On mem_rdy → WAIT_NACK.
  - WAIT_NACK: done=1. When req=0, clear done and go to IDLE.
- Beat counter (7 bits):
  - Increments on rd_data_valid in READ_DATA0, READ_DATA2 and READ_DATA1, because beats can return before all commands are issued.
  - Ignored in every other state.
  - Completion check uses the counter value including the beat arriving in the same cycle.
- Total commands issued per read = burst_len+1. burst_cnt never exceeds burst_len.
- rd_beat is rd_data_valid delayed one cycle, gated to the read states.
- Boundary and error conditions:
  - req dropping mid-burst is ignored; the burst completes and WAIT_NACK sees req=0 and exits on the next cycle.
  - calib_done dropping mid-burst is ignored.
  - mem_rdy stuck low holds the current state indefinitely; there is no timeout.
  - burst_len=63 gives 64 commands and 64 beats; counters must not wrap early.
  - Reset mid-burst returns to IDLE with cmd_en deasserted immediately (asynchronously).
  - Simultaneous mem_rdy and rd_data_valid in READ_DATA2 are both honoured in the same cycle.

Decomposition:
- The mpmc11_state_t enum (IDLE, PRESET1, PRESET2, READ_DATA0/1/2, WRITE_DATA0/1, WAIT_NACK) lives in mpmc11_pkg and is shared with the address generator.
- The CMD_RD/CMD_WR constants also go in mpmc11_pkg.
- No sub-module: the beat counter is inline.

Test Plan:
- Reset, then calib_done=0 with req=1 → state stays IDLE, cmd_en=0. Raise calib_done → PRESET1 next cycle.
- Read, req_adr=0x1000, req_len=0, mem_rdy=1, one rd_data_valid 3 cycles later → exactly 1 command, READ_DATA0→READ_DATA1→WAIT_NACK, done=1. Drop req → IDLE.
- Read, req_len=3, mem_rdy toggling 1/0 → 4 commands, burst_cnt steps 0,1,2,3. Exit to WAIT_NACK only after the 4th beat, including a beat arriving during READ_DATA2.
- Write, req_we=1, wdf_rdy delayed 2 cycles, then mem_rdy=1 → one wdf_wren/wdf_end beat, then one CMD_WR command, done=1. burst_len output=0 even though req_len=5.
- Read, req_len=63 → 64 commands and 64 beats counted without wrap, then WAIT_NACK.
- Assert rst low in READ_DATA2 with burst_cnt=2 → state=IDLE, cmd_en=0, burst_cnt=0 immediately. A fresh request after release proceeds normally.
